// File: rtl/arb_requester.sv
// Requester-side agent for the 4-way shared-resource arbiter: one burst per command, req/gnt handshake.
// Optional request timeout is enabled by defining ARB_REQ_TIMEOUT_EN.
module arb_requester #(
  parameter int LEN_W   = 4,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  output logic             req,
  input  logic             gnt,
  output logic             beat_valid,
  output logic [LEN_W-1:0] beat_idx,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2, REL = 2'd3} state_t;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GLAST = GW'(GAP - 1);

  if (GAP < 1) begin : g_gap_chk
    $error("arb_requester: GAP must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("arb_requester: TIMEOUT must be >= 1");
  end

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [GW-1:0]    gap_cnt;

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);
  logic [WW-1:0] wcnt;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      req       <= 1'b0;
      cmd_ready <= 1'b0;
      done      <= 1'b0;
      beat_idx  <= '0;
      gap_cnt   <= '0;
`ifdef ARB_REQ_TIMEOUT_EN
      wcnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            len       <= cmd_len;
            beat_idx  <= '0;
            state     <= REQ;
            req       <= 1'b1;
            cmd_ready <= 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
            wcnt      <= '0;
`endif
          end
        end
        REQ: begin
          if (gnt) begin
            state <= XFER;
          end
`ifdef ARB_REQ_TIMEOUT_EN
          // Command is abandoned on timeout; REL still enforces the gap.
          else if (wcnt == WLAST) begin
            state   <= REL;
            req     <= 1'b0;
            gap_cnt <= '0;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
`endif
        end
        XFER: begin
          if (gnt) begin
            if (beat_idx == len) begin
              state   <= REL;
              req     <= 1'b0;
              done    <= 1'b1;
              gap_cnt <= '0;
            end else begin
              beat_idx <= beat_idx + 1'b1;
            end
          end else begin
            // Grant lost: idx is held so the burst resumes without repeats.
            state <= REQ;
`ifdef ARB_REQ_TIMEOUT_EN
            wcnt  <= '0;
`endif
          end
        end
        REL: begin
          if (gap_cnt == GLAST) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign beat_valid = (state == XFER) && gnt;

`ifdef ARB_REQ_TIMEOUT_EN
  assign err = (state == REQ) && !gnt && (wcnt == WLAST);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester: cycle vector table plus scoreboard-checked burst sequences.
module tb_arb_requester;
  localparam int LEN_W   = 4;
  localparam int GAP     = 1;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rstn, cmd_valid, gnt;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_ready, req, beat_valid, done, err;
  logic [LEN_W-1:0] beat_idx;

  always #5 clk = ~clk;

  arb_requester #(.LEN_W(LEN_W), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .req(req), .gnt(gnt), .beat_valid(beat_valid),
    .beat_idx(beat_idx), .done(done), .err(err)
  );

  typedef struct {
    logic             rstn, cv;
    logic [LEN_W-1:0] len;
    logic             g;
    logic             req, rdy, bv;
    logic [LEN_W-1:0] idx;
    logic             ic;
    logic             done, err;
  } vec_t;

  vec_t vt[$];
  int   checks = 0, errors = 0;
  int   exp_q[$];
  int   sb_exp;
  bit   sb_en = 1'b0;
  int   done_cnt = 0, beat_cnt = 0;

  task automatic add(input logic r, input logic cv, input int len, input logic g,
                     input logic q, input logic rdy, input logic bv, input int idx,
                     input logic ic, input logic d, input logic e);
    vec_t v;
    v.rstn = r; v.cv = cv; v.len = LEN_W'(len); v.g = g;
    v.req = q; v.rdy = rdy; v.bv = bv; v.idx = LEN_W'(idx); v.ic = ic;
    v.done = d; v.err = e;
    vt.push_back(v);
  endtask

  // Scoreboard: beats popped in order as the DUT issues them.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else if (sb_en) begin
      if (beat_valid) begin
        beat_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra_beat got idx=%0d want no beat", beat_idx);
        end else begin
          sb_exp = exp_q.pop_front();
          if (beat_idx !== LEN_W'(sb_exp)) begin
            errors++;
            $display("FAIL sb_beat_idx got %0d want %0d", beat_idx, sb_exp);
          end
        end
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL sb_done_early got %0d beats pending want 0", exp_q.size());
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic send_cmd(input int len);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_len   = LEN_W'(len);
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cmd_ready) begin
      errors++;
      $display("FAIL accept_timeout got cmd_ready=%b want 1", cmd_ready);
    end else begin
      for (int b = 0; b <= len; b++) exp_q.push_back(b);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL done_timeout got no done want done within %0d cycles", budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  bad;
    bit  found;
    rstn = 1'b0; cmd_valid = 1'b0; cmd_len = '0; gnt = 1'b0;
    @(posedge clk); #1;

    //  rstn cv len g | req rdy bv idx ic done err
    add(0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0);  // second reset cycle
    add(1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0);  // released, ready not yet up
    add(1, 1, 3, 1,   0, 1, 0, 0, 0, 0, 0);  // accept len=3
    add(1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0);  // REQ
    add(1, 0, 0, 1,   1, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 1,   1, 0, 1, 1, 1, 0, 0);
    add(1, 0, 0, 1,   1, 0, 1, 2, 1, 0, 0);
    add(1, 0, 0, 1,   1, 0, 1, 3, 1, 0, 0);
    add(1, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0);  // REL, done, gnt ignored
    add(1, 1, 0, 1,   0, 1, 0, 0, 0, 0, 0);  // IDLE again, accept len=0
    add(1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1,   1, 0, 1, 0, 1, 0, 0);  // single beat
    add(1, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0);
    add(1, 1, 7, 1,   0, 1, 0, 0, 0, 0, 0);  // accept len=7
    add(1, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1,   1, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 1,   1, 0, 1, 1, 1, 0, 0);
    add(0, 0, 0, 1,   1, 0, 1, 2, 1, 0, 0);  // reset during idx 2
    add(1, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0);  // aborted, gnt in IDLE ignored
    add(1, 0, 0, 0,   0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      rstn = vt[i].rstn; cmd_valid = vt[i].cv; cmd_len = vt[i].len; gnt = vt[i].g;
      @(negedge clk);
      checks++;
      if (req !== vt[i].req || cmd_ready !== vt[i].rdy || beat_valid !== vt[i].bv ||
          done !== vt[i].done || err !== vt[i].err || (vt[i].ic && beat_idx !== vt[i].idx)) begin
        errors++;
        $display("FAIL vec%0d got req=%b rdy=%b bv=%b idx=%0d done=%b err=%b want req=%b rdy=%b bv=%b idx=%0d done=%b err=%b",
                 i, req, cmd_ready, beat_valid, beat_idx, done, err,
                 vt[i].req, vt[i].rdy, vt[i].bv, vt[i].idx, vt[i].done, vt[i].err);
      end
      @(posedge clk); #1;
    end

    // New command after mid-burst reset completes with all 8 beats.
    sb_en = 1'b1;
    beat_cnt = 0; done_cnt = 0;
    gnt = 1'b1;
    send_cmd(7);
    wait_done(50);
    check("len7_beats", beat_cnt, 8);
    check("len7_done", done_cnt, 1);

    // Grant drops for 3 cycles after idx 2; burst resumes at idx 3.
    beat_cnt = 0; done_cnt = 0;
    repeat (3) begin @(posedge clk); #1; end
    send_cmd(5);
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (beat_valid && beat_idx == 2) found = 1'b1;
      @(posedge clk); #1;
    end
    check("drop_saw_idx2", int'(found), 1);
    gnt = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (beat_valid !== 1'b0 || req !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    check("drop_no_beat", bad, 0);
    gnt = 1'b1;
    wait_done(50);
    repeat (4) begin @(posedge clk); #1; end
    check("drop_beats", beat_cnt, 6);
    check("drop_single_done", done_cnt, 1);

`ifdef ARB_REQ_TIMEOUT_EN
    // No grant: err on the TIMEOUT-th REQ cycle, then REL, command discarded.
    done_cnt = 0;
    gnt = 1'b0;
    send_cmd(2);
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      checks++;
      if (req !== 1'b1 || err !== (k == TIMEOUT)) begin
        errors++;
        $display("FAIL to_wait cyc%0d got req=%b err=%b want req=1 err=%b", k, req, err, (k == TIMEOUT));
      end
      @(posedge clk); #1;
    end
    exp_q.delete();
    @(negedge clk);
    checks++;
    if (req !== 1'b0 || err !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL to_rel got req=%b err=%b done=%b rdy=%b want 0 0 0 0", req, err, done, cmd_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("to_idle_ready", int'(cmd_ready), 1);
    check("to_no_done", done_cnt, 0);
    @(posedge clk); #1;
`else
    // No grant and no timeout: request is held indefinitely.
    beat_cnt = 0; done_cnt = 0;
    gnt = 1'b0;
    send_cmd(2);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (req !== 1'b1 || err !== 1'b0 || beat_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("nogrant_hold", bad, 0);
    gnt = 1'b1;
    wait_done(50);
    check("nogrant_beats", beat_cnt, 3);
    check("nogrant_done", done_cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
